// File: rtl/clock_divider_if.sv
// Output bundle of clock_divider: divided square wave, plus the rise pulse
// when built with CLOCK_DIVIDER_TICK_EN.
interface clock_divider_if;
    logic clk_out;
`ifdef CLOCK_DIVIDER_TICK_EN
    logic tick;

    modport master (output clk_out, output tick);
    modport slave  (input  clk_out, input  tick);
`else
    modport master (output clk_out);
    modport slave  (input  clk_out);
`endif
endinterface

// File: rtl/clock_divider.sv
// Free-running 50 % duty divider: clk_out toggles every HALF input cycles.
// Optional one-cycle rise pulse 'tick' when CLOCK_DIVIDER_TICK_EN is defined.
module clock_divider #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int OUT_FREQ_HZ = 1
) (
    input  logic             clk,
    input  logic             rst,
    clock_divider_if.master  div
);

    localparam int HALF  = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
    localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(HALF - 1);

    if (HALF == 0) begin : g_half_check
        $error("clock_divider: CLK_FREQ_HZ must be at least 2*OUT_FREQ_HZ");
    end

    logic [CNT_W-1:0] cnt_reg;
    logic             clk_out_reg;
    logic             at_term;

    assign at_term = (cnt_reg == TERM);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
        end else if (at_term) begin
            cnt_reg     <= '0;
            clk_out_reg <= ~clk_out_reg;
        end else begin
            cnt_reg     <= cnt_reg + CNT_W'(1);
        end
    end

    assign div.clk_out = clk_out_reg;

`ifdef CLOCK_DIVIDER_TICK_EN
    logic tick_reg;

    // Registered on the same edge that raises clk_out, so both rise together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_reg <= 1'b0;
        end else begin
            tick_reg <= at_term & ~clk_out_reg;
        end
    end

    assign div.tick = tick_reg;
`endif

endmodule

// File: tb/tb_clock_divider.sv
// Scoreboard bench for clock_divider: three instances (HALF = 5, 1, 500), expected
// toggle edges queued by the stimulus and checked by a negedge monitor.
module tb_clock_divider;

    typedef struct {
        int   edge_n;
        logic val;
    } exp_t;

    localparam int HALF_T [3] = '{5, 1, 500};

    logic       clk = 1'b0;
    logic [2:0] rst_v;
    logic [2:0] clkout_v;
    logic [2:0] tick_v;

    always #5 clk = ~clk;

    clock_divider_if if0 ();
    clock_divider_if if1 ();
    clock_divider_if if2 ();

    clock_divider #(.CLK_FREQ_HZ(10),   .OUT_FREQ_HZ(1)) u_div0 (.clk(clk), .rst(rst_v[0]), .div(if0.master));
    clock_divider #(.CLK_FREQ_HZ(2),    .OUT_FREQ_HZ(1)) u_div1 (.clk(clk), .rst(rst_v[1]), .div(if1.master));
    clock_divider #(.CLK_FREQ_HZ(1000), .OUT_FREQ_HZ(1)) u_div2 (.clk(clk), .rst(rst_v[2]), .div(if2.master));

    assign clkout_v = {if2.clk_out, if1.clk_out, if0.clk_out};
`ifdef CLOCK_DIVIDER_TICK_EN
    assign tick_v = {if2.tick, if1.tick, if0.tick};
`else
    assign tick_v = 3'b000;
`endif

    int   compared   = 0;
    int   mismatched = 0;
    int   ecnt [3]   = '{0, 0, 0};
    logic prev [3]   = '{1'b0, 1'b0, 1'b0};
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t q2 [$];

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edge k after release toggles clk_out whenever k is a multiple of HALF.
    task automatic push_window(input int idx, input int n);
        exp_t e;
        for (int k = 1; k <= n; k++) begin
            if (k % HALF_T[idx] == 0) begin
                e.edge_n = k;
                e.val    = ((k / HALF_T[idx]) % 2 == 1);
                case (idx)
                    0:       q0.push_back(e);
                    1:       q1.push_back(e);
                    default: q2.push_back(e);
                endcase
            end
        end
    endtask

    task automatic observe(input int idx, input logic cur, input logic tk);
        exp_t e;
        bit   have;
        if (!rst_v[idx]) begin
            prev[idx] = 1'b0;
            return;
        end
`ifdef CLOCK_DIVIDER_TICK_EN
        chk($sformatf("tick%0d_edge%0d", idx, ecnt[idx]), int'(tk),
            int'(ecnt[idx] > 0 && ecnt[idx] % (2 * HALF_T[idx]) == HALF_T[idx]));
`else
        if (tk) chk($sformatf("tick%0d_absent", idx), int'(tk), 0);
`endif
        if (cur !== prev[idx]) begin
            have = 1'b0;
            case (idx)
                0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            endcase
            if (!have) begin
                chk($sformatf("unexpected_toggle%0d", idx), ecnt[idx], -1);
            end else begin
                chk($sformatf("toggle_edge%0d", idx), ecnt[idx], e.edge_n);
                chk($sformatf("toggle_val%0d", idx), int'(cur), int'(e.val));
                $display("div%0d: clk_out -> %0b at edge %0d", idx, cur, ecnt[idx]);
            end
            prev[idx] = cur;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 3; i++) ecnt[i] = rst_v[i] ? ecnt[i] + 1 : 0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) observe(i, clkout_v[i], tick_v[i]);
        end
    end

    task automatic run_window(input int n);
        for (int i = 0; i < 3; i++) push_window(i, n);
        @(negedge clk);
        #1 rst_v = 3'b111;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        chk("pending_q0", q0.size(), 0);
        chk("pending_q1", q1.size(), 0);
        chk("pending_q2", q2.size(), 0);
    endtask

    initial begin
        rst_v = 3'b000;
        repeat (5) begin
            @(negedge clk);
            #1;
            chk("rst_hold_out", int'(clkout_v), 0);
            chk("rst_hold_cnt", int'(u_div0.cnt_reg), 0);
        end

        run_window(1005);
        // Edge 1005 is the 201st toggle of the HALF=5 divider, so it sits high.
        chk("pre_drop_high0", int'(clkout_v[0]), 1);
        #1 rst_v = 3'b000;
        #1;
        chk("async_drop_out", int'(clkout_v), 0);
        chk("async_drop_tick", int'(tick_v), 0);

        repeat (2) @(negedge clk);
        run_window(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
